// File: rtl/jtag_tap_oversampled_if.sv
// JTAG pin bundle shared by the oversampled TAP and its driver.
// The master drives TCK/TMS/TDI/TRSTn; the TAP is the slave.
interface jtag_tap_oversampled_if;
   logic tck;
   logic tms;
   logic tdi;
   logic trst_n;
   logic tdo;
   logic tdo_oe;

   modport master (
      output tck, tms, tdi, trst_n,
      input  tdo, tdo_oe
   );

   modport slave (
      input  tck, tms, tdi, trst_n,
      output tdo, tdo_oe
   );
endinterface

// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP clocked from clk; pins are synchronised and edge-detected.
// Provides IR, IDCODE, BYPASS and NUM_TDR capture/update chains.
module jtag_tap_oversampled #(
   parameter int          IR_WIDTH    = 3,
   parameter int          DR_WIDTH    = 8,
   parameter int          NUM_TDR     = 4,
   parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   jtag_tap_oversampled_if.slave       jtag,
   input  logic [NUM_TDR*DR_WIDTH-1:0] tdr_in,
   output logic [NUM_TDR*DR_WIDTH-1:0] tdr_out,
   output logic [NUM_TDR-1:0]          tdr_upd,
   output logic [3:0]                  tap_state,
   output logic [IR_WIDTH-1:0]         ir_out,
   output logic                        test_logic_reset
);

   typedef enum logic [3:0] {
      TLR     = 4'd0,
      RTI     = 4'd1,
      SELDR   = 4'd2,
      CAPDR   = 4'd3,
      SHDR    = 4'd4,
      EX1DR   = 4'd5,
      PAUSEDR = 4'd6,
      EX2DR   = 4'd7,
      UPDDR   = 4'd8,
      SELIR   = 4'd9,
      CAPIR   = 4'd10,
      SHIR    = 4'd11,
      EX1IR   = 4'd12,
      PAUSEIR = 4'd13,
      EX2IR   = 4'd14,
      UPDIR   = 4'd15
   } state_t;

   localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

   logic [SYNC_STAGES-1:0] tck_s;
   logic [SYNC_STAGES-1:0] tms_s;
   logic [SYNC_STAGES-1:0] tdi_s;
   logic [SYNC_STAGES-1:0] trst_s;
   logic                   tck_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tck_s  <= '0;
         tms_s  <= '0;
         tdi_s  <= '0;
         trst_s <= '1;
         tck_d  <= 1'b0;
      end else begin
         tck_s  <= {tck_s[SYNC_STAGES-2:0], jtag.tck};
         tms_s  <= {tms_s[SYNC_STAGES-2:0], jtag.tms};
         tdi_s  <= {tdi_s[SYNC_STAGES-2:0], jtag.tdi};
         trst_s <= {trst_s[SYNC_STAGES-2:0], jtag.trst_n};
         tck_d  <= tck_s[SYNC_STAGES-1];
      end
   end

   logic tck_rise;
   logic tck_fall;
   logic tms_q;
   logic tdi_q;
   logic trst_q;

   assign tck_rise = tck_s[SYNC_STAGES-1] & ~tck_d;
   assign tck_fall = ~tck_s[SYNC_STAGES-1] & tck_d;
   assign tms_q    = tms_s[SYNC_STAGES-1];
   assign tdi_q    = tdi_s[SYNC_STAGES-1];
   assign trst_q   = trst_s[SYNC_STAGES-1];

   function automatic state_t next_state(state_t s, logic m);
      unique case (s)
         TLR:     next_state = m ? TLR     : RTI;
         RTI:     next_state = m ? SELDR   : RTI;
         SELDR:   next_state = m ? SELIR   : CAPDR;
         CAPDR:   next_state = m ? EX1DR   : SHDR;
         SHDR:    next_state = m ? EX1DR   : SHDR;
         EX1DR:   next_state = m ? UPDDR   : PAUSEDR;
         PAUSEDR: next_state = m ? EX2DR   : PAUSEDR;
         EX2DR:   next_state = m ? UPDDR   : SHDR;
         UPDDR:   next_state = m ? SELDR   : RTI;
         SELIR:   next_state = m ? TLR     : CAPIR;
         CAPIR:   next_state = m ? EX1IR   : SHIR;
         SHIR:    next_state = m ? EX1IR   : SHIR;
         EX1IR:   next_state = m ? UPDIR   : PAUSEIR;
         PAUSEIR: next_state = m ? EX2IR   : PAUSEIR;
         EX2IR:   next_state = m ? UPDIR   : SHIR;
         UPDIR:   next_state = m ? SELDR   : RTI;
         default: next_state = TLR;
      endcase
   endfunction

   state_t                state;
   state_t                state_nx;
   logic [IR_WIDTH-1:0]   ir_sr;
   logic [31:0]           id_sr;
   logic                  byp_sr;
   logic [DR_WIDTH-1:0]   tdr_sr [NUM_TDR];
   logic [NUM_TDR-1:0]    sel_tdr;
   logic                  sel_id;
   logic                  dr_bit0;

   assign state_nx = next_state(state, tms_q);
   assign sel_id   = (ir_out == IR_IDCODE);

   always_comb begin
      sel_tdr = '0;
      for (int k = 0; k < NUM_TDR; k++)
         sel_tdr[k] = (ir_out == IR_WIDTH'(k + 2));
   end

   // Codes matching neither IDCODE nor a TDR fall through to BYPASS
   always_comb begin
      dr_bit0 = byp_sr;
      if (sel_id)
         dr_bit0 = id_sr[0];
      for (int k = 0; k < NUM_TDR; k++)
         if (sel_tdr[k])
            dr_bit0 = tdr_sr[k][0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= TLR;
         ir_out      <= IR_IDCODE;
         ir_sr       <= '0;
         id_sr       <= '0;
         byp_sr      <= 1'b0;
         tdr_out     <= '0;
         tdr_upd     <= '0;
         jtag.tdo    <= 1'b0;
         jtag.tdo_oe <= 1'b0;
         for (int k = 0; k < NUM_TDR; k++)
            tdr_sr[k] <= '0;
      end else begin
         tdr_upd <= '0;
         if (!trst_q) begin
            state  <= TLR;
            ir_out <= IR_IDCODE;
         end else if (tck_rise) begin
            state <= state_nx;
            unique case (state)
               CAPIR: ir_sr <= IR_WIDTH'(1);
               SHIR:  ir_sr <= {tdi_q, ir_sr[IR_WIDTH-1:1]};
               UPDIR: ir_out <= ir_sr;
               CAPDR: begin
                  if (sel_id)
                     id_sr <= IDCODE_VAL;
                  else if (sel_tdr == '0)
                     byp_sr <= 1'b0;
                  for (int k = 0; k < NUM_TDR; k++)
                     if (sel_tdr[k])
                        tdr_sr[k] <= tdr_in[k*DR_WIDTH +: DR_WIDTH];
               end
               SHDR: begin
                  if (sel_id)
                     id_sr <= {tdi_q, id_sr[31:1]};
                  else if (sel_tdr == '0)
                     byp_sr <= tdi_q;
                  for (int k = 0; k < NUM_TDR; k++)
                     if (sel_tdr[k])
                        tdr_sr[k] <= {tdi_q, tdr_sr[k][DR_WIDTH-1:1]};
               end
               UPDDR: begin
                  for (int k = 0; k < NUM_TDR; k++)
                     if (sel_tdr[k]) begin
                        tdr_out[k*DR_WIDTH +: DR_WIDTH] <= tdr_sr[k];
                        tdr_upd[k] <= 1'b1;
                     end
               end
               default: ;
            endcase
            if (state_nx == TLR)
               ir_out <= IR_IDCODE;
         end else if (tck_fall) begin
            jtag.tdo_oe <= (state == SHIR) || (state == SHDR);
            if (state == SHIR)
               jtag.tdo <= ir_sr[0];
            else if (state == SHDR)
               jtag.tdo <= dr_bit0;
         end
      end
   end

   assign tap_state        = state;
   assign test_logic_reset = (state == TLR);

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Directed bench for jtag_tap_oversampled.
// Drives TCK slowly relative to clk and checks hand-computed results.
module tb_jtag_tap_oversampled;

   logic        clk;
   logic        rst_n;
   logic [31:0] tdr_in;
   logic [31:0] tdr_out;
   logic [3:0]  tdr_upd;
   logic [3:0]  tap_state;
   logic [2:0]  ir_out;
   logic        test_logic_reset;

   int n_chk;
   int n_pass;
   int upd_cnt;
   logic [3:0] upd_last;

   jtag_tap_oversampled_if jt ();

   jtag_tap_oversampled dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .jtag             (jt),
      .tdr_in           (tdr_in),
      .tdr_out          (tdr_out),
      .tdr_upd          (tdr_upd),
      .tap_state        (tap_state),
      .ir_out           (ir_out),
      .test_logic_reset (test_logic_reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (tdr_upd != 4'b0) begin
         upd_cnt  = upd_cnt + 1;
         upd_last = tdr_upd;
      end

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (obs === exp)
         n_pass = n_pass + 1;
      else
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tck_cycle(input logic m, input logic d);
      jt.tms = m;
      jt.tdi = d;
      repeat (4) @(negedge clk);
      jt.tck = 1'b1;
      repeat (8) @(negedge clk);
      jt.tck = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic shift(input int n,
                        input logic [63:0] din,
                        output logic [63:0] dout);
      dout    = '0;
      dout[0] = jt.tdo;
      for (int i = 0; i < n; i++) begin
         tck_cycle(i == n - 1, din[i]);
         if (i < n - 1)
            dout[i+1] = jt.tdo;
      end
   endtask

   task automatic load_ir(input logic [2:0] ir,
                          output logic [63:0] cap);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      shift(3, {61'b0, ir}, cap);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic go_shdr();
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic upd_dr();
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   initial begin
      logic [63:0] d;
      int          lat;
      n_chk    = 0;
      n_pass   = 0;
      upd_cnt  = 0;
      upd_last = '0;
      tdr_in   = 32'h7766_3C11;
      jt.tck   = 1'b0;
      jt.tms   = 1'b0;
      jt.tdi   = 1'b0;
      jt.trst_n = 1'b1;
      rst_n    = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_state", 64'(tap_state), 64'd0);
      check("rst_ir", 64'(ir_out), 64'd1);
      check("rst_tdr_out", 64'(tdr_out), 64'd0);
      check("rst_tdo_oe", 64'(jt.tdo_oe), 64'd0);
      check("rst_tdo", 64'(jt.tdo), 64'd0);
      check("rst_tlr", 64'(test_logic_reset), 64'd1);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      jt.tck = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (tap_state == 4'd1) begin
            lat = i;
            break;
         end
      end
      check("rti_latency", 64'(lat), 64'd3);
      jt.tck = 1'b0;
      repeat (8) @(negedge clk);

      go_shdr();
      check("shdr_state", 64'(tap_state), 64'd4);
      check("shdr_oe", 64'(jt.tdo_oe), 64'd1);
      shift(33, 64'h0_CAFE_BABE, d);
      check("idcode", d[31:0], 64'h1000_0001);
      check("idcode_wrap", 64'(d[32]), 64'd0);
      check("ex1dr_oe", 64'(jt.tdo_oe), 64'd0);
      upd_dr();
      check("idcode_no_upd", 64'(upd_cnt), 64'd0);

      load_ir(3'd2, d);
      check("ir_capture", d[2:0], 64'd1);
      check("ir_tdr0", 64'(ir_out), 64'd2);
      go_shdr();
      shift(8, 64'hA5, d);
      check("tdr0_cap", d[7:0], 64'h11);
      upd_cnt = 0;
      upd_dr();
      check("tdr0_out", 64'(tdr_out), 64'h0000_00A5);
      check("tdr0_upd_cnt", 64'(upd_cnt), 64'd1);
      check("tdr0_upd", 64'(upd_last), 64'b0001);

      load_ir(3'd3, d);
      go_shdr();
      shift(8, 64'h5A, d);
      check("tdr1_cap", d[7:0], 64'h3C);
      upd_cnt = 0;
      upd_dr();
      check("tdr1_out", 64'(tdr_out), 64'h0000_5AA5);
      check("tdr1_upd_cnt", 64'(upd_cnt), 64'd1);
      check("tdr1_upd", 64'(upd_last), 64'b0010);

      load_ir(3'd7, d);
      check("ir_bypass", 64'(ir_out), 64'd7);
      go_shdr();
      shift(4, 64'b1011, d);
      check("bypass", d[3:0], 64'b0110);
      upd_dr();

      load_ir(3'd2, d);
      go_shdr();
      upd_cnt = 0;
      tck_cycle(1'b0, 1'b1);
      tck_cycle(1'b0, 1'b1);
      tck_cycle(1'b0, 1'b1);
      jt.trst_n = 1'b0;
      repeat (6) @(negedge clk);
      check("trst_state", 64'(tap_state), 64'd0);
      check("trst_ir", 64'(ir_out), 64'd1);
      check("trst_tdr_kept", 64'(tdr_out), 64'h0000_5AA5);
      check("trst_no_upd", 64'(upd_cnt), 64'd0);
      jt.trst_n = 1'b1;
      repeat (8) @(negedge clk);

      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      check("shir_state", 64'(tap_state), 64'd11);
      for (int i = 0; i < 5; i++)
         tck_cycle(1'b1, 1'b0);
      check("tms5_tlr", 64'(tap_state), 64'd0);
      check("tms5_tlr_flag", 64'(test_logic_reset), 64'd1);

      tck_cycle(1'b0, 1'b0);
      go_shdr();
      tck_cycle(1'b0, 1'b1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rstn_state", 64'(tap_state), 64'd0);
      check("rstn_tdr_out", 64'(tdr_out), 64'd0);
      check("rstn_oe", 64'(jt.tdo_oe), 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
